// File: rtl/mult_div_unit_if.sv
// Operand/result bundle between the E-stage controller and the HI/LO multiply/divide unit.
// Signal names follow the pipeline's own names (start, md_op, A, B, hi, lo, ...).
interface mult_div_unit_if;
  // Handshake: the controller pulses start for one cycle only when stall_req is low.
  // The unit raises busy from the next edge until its result commits. A start seen
  // while busy is ignored. stall_req = start | busy, so D holds HI/LO users until
  // busy falls.
  logic        start;
  logic [1:0]  md_op;
  logic        hilo_we;
  logic        hilo_sel;
  logic [31:0] A;
  logic [31:0] B;
  logic        busy;
  logic        stall_req;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        dbg_state;

  modport master (
    output start, md_op, hilo_we, hilo_sel, A, B,
    input  busy, stall_req, hi, lo, dbg_state
  );

  modport slave (
    input  start, md_op, hilo_we, hilo_sel, A, B,
    output busy, stall_req, hi, lo, dbg_state
  );
endinterface

// File: rtl/mult_div_unit.sv
// Fixed-latency mult/multu/div/divu unit with HI/LO registers and mthi/mtlo writes.
// The full result is computed at start and held pending until the latency elapses.
module mult_div_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic         clk,
  input  logic         reset,
  mult_div_unit_if.slave md
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW         = $clog2(MAX_CYCLES + 1);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  state_t        r_state;
  state_t        w_next_state;
  logic [CW-1:0] r_cnt;
  logic [31:0]   r_hi;
  logic [31:0]   r_lo;
  logic [31:0]   r_pend_hi;
  logic [31:0]   r_pend_lo;
  logic          r_pend_ok;

  logic          w_load;
  logic          w_commit;
  logic          w_mt;

  logic signed [63:0] w_prod_s;
  logic        [63:0] w_prod_u;
  logic        [31:0] w_abs_a;
  logic        [31:0] w_abs_b;
  logic        [31:0] w_sdiv_b;
  logic        [31:0] w_udiv_b;
  logic        [31:0] w_mag_q;
  logic        [31:0] w_mag_r;
  logic        [31:0] w_res_hi;
  logic        [31:0] w_res_lo;
  logic               w_div_zero;

  // Signed divide works on magnitudes so 0x80000000 / -1 yields 0x80000000 without overflow.
  assign w_prod_s   = $signed({{32{md.A[31]}}, md.A}) * $signed({{32{md.B[31]}}, md.B});
  assign w_prod_u   = {32'd0, md.A} * {32'd0, md.B};
  assign w_abs_a    = md.A[31] ? (32'd0 - md.A) : md.A;
  assign w_abs_b    = md.B[31] ? (32'd0 - md.B) : md.B;
  assign w_div_zero = (md.B == 32'd0);
  assign w_sdiv_b   = w_div_zero ? 32'd1 : w_abs_b;
  assign w_udiv_b   = w_div_zero ? 32'd1 : md.B;
  assign w_mag_q    = w_abs_a / w_sdiv_b;
  assign w_mag_r    = w_abs_a % w_sdiv_b;

  always_comb begin
    w_res_hi = 32'd0;
    w_res_lo = 32'd0;
    case (md.md_op)
      2'b00: begin
        w_res_hi = w_prod_s[63:32];
        w_res_lo = w_prod_s[31:0];
      end
      2'b01: begin
        w_res_hi = w_prod_u[63:32];
        w_res_lo = w_prod_u[31:0];
      end
      2'b10: begin
        w_res_lo = (md.A[31] ^ md.B[31]) ? (32'd0 - w_mag_q) : w_mag_q;
        w_res_hi = md.A[31] ? (32'd0 - w_mag_r) : w_mag_r;
      end
      default: begin
        w_res_lo = md.A / w_udiv_b;
        w_res_hi = md.A % w_udiv_b;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_load       = 1'b0;
    w_commit     = 1'b0;
    w_mt         = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (md.start) begin
          w_load       = 1'b1;
          w_next_state = S_RUN;
        end else if (md.hilo_we) begin
          w_mt = 1'b1;
        end
      end
      S_RUN: begin
        if (r_cnt == CW'(1)) begin
          w_commit     = r_pend_ok;
          w_next_state = S_IDLE;
        end
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt     <= '0;
      r_hi      <= 32'd0;
      r_lo      <= 32'd0;
      r_pend_hi <= 32'd0;
      r_pend_lo <= 32'd0;
      r_pend_ok <= 1'b0;
    end else begin
      if (w_load) begin
        r_pend_hi <= w_res_hi;
        r_pend_lo <= w_res_lo;
        // A divide by zero still runs its full latency but leaves HI/LO untouched.
        r_pend_ok <= !(md.md_op[1] && w_div_zero);
        r_cnt     <= md.md_op[1] ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
      end else if (r_state == S_RUN) begin
        r_cnt <= r_cnt - CW'(1);
      end
      if (w_commit) begin
        r_hi <= r_pend_hi;
        r_lo <= r_pend_lo;
      end
      if (w_mt) begin
        if (md.hilo_sel) begin
          r_hi <= md.A;
        end else begin
          r_lo <= md.A;
        end
      end
    end
  end

  assign md.busy      = (r_state == S_RUN);
  assign md.stall_req = md.start | md.busy;
  assign md.hi        = r_hi;
  assign md.lo        = r_lo;
  assign md.dbg_state = r_state;

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: directed cases, random operations against an
// arithmetic reference model, ignored requests, back-to-back issue and mid-run reset.
module tb_mult_div_unit;

  localparam int MULT_N = 5;
  localparam int DIV_N  = 10;

  logic clk;
  logic reset;
  int   errors;
  int   checks;

  logic [31:0] m_hi;
  logic [31:0] m_lo;

  mult_div_unit_if bus ();

  mult_div_unit #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
    .clk   (clk),
    .reset (reset),
    .md    (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: plain 64-bit arithmetic on the operands as MIPS defines the ops.
  task automatic model_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    longint      sa;
    longint      sb;
    longint      sq;
    longint      sr;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (op)
      2'b00: begin
        p    = 64'(sa * sb);
        m_hi = p[63:32];
        m_lo = p[31:0];
      end
      2'b01: begin
        p    = {32'd0, a} * {32'd0, b};
        m_hi = p[63:32];
        m_lo = p[31:0];
      end
      2'b10: begin
        if (b != 32'd0) begin
          sq   = sa / sb;
          sr   = sa % sb;
          m_lo = sq[31:0];
          m_hi = sr[31:0];
        end
      end
      default: begin
        if (b != 32'd0) begin
          m_lo = a / b;
          m_hi = a % b;
        end
      end
    endcase
  endtask

  // Called at a negedge; returns at the negedge where busy has fallen.
  task automatic run_op(input string name, input logic [1:0] op,
                        input logic [31:0] a, input logic [31:0] b);
    int          cycles;
    int          n_exp;
    logic [31:0] old_hi;
    logic [31:0] old_lo;
    old_hi = m_hi;
    old_lo = m_lo;
    n_exp  = op[1] ? DIV_N : MULT_N;
    bus.start = 1'b1;
    bus.md_op = op;
    bus.A     = a;
    bus.B     = b;
    #1;
    checks++;
    if (bus.stall_req !== 1'b1) begin
      errors++;
      $display("FAIL %s stall_on_start: got %b want 1", name, bus.stall_req);
    end
    @(negedge clk);
    bus.start = 1'b0;
    bus.A     = $urandom;
    bus.B     = $urandom;
    cycles    = 0;
    while (bus.busy === 1'b1 && cycles < 40) begin
      cycles++;
      checks++;
      if (bus.hi !== old_hi || bus.lo !== old_lo || bus.stall_req !== 1'b1) begin
        errors++;
        $display("FAIL %s hold_while_busy: hi=%h lo=%h stall=%b want hi=%h lo=%h stall=1",
                 name, bus.hi, bus.lo, bus.stall_req, old_hi, old_lo);
      end
      @(negedge clk);
    end
    checks++;
    if (cycles != n_exp) begin
      errors++;
      $display("FAIL %s busy_cycles: got %0d want %0d", name, cycles, n_exp);
    end
    model_op(op, a, b);
    checks++;
    if (bus.hi !== m_hi || bus.lo !== m_lo) begin
      errors++;
      $display("FAIL %s result: hi=%h lo=%h want hi=%h lo=%h", name, bus.hi, bus.lo, m_hi, m_lo);
    end
  endtask

  task automatic do_mt(input logic sel, input logic [31:0] val);
    bus.hilo_we  = 1'b1;
    bus.hilo_sel = sel;
    bus.A        = val;
    @(negedge clk);
    bus.hilo_we = 1'b0;
    if (sel) m_hi = val;
    else     m_lo = val;
    checks++;
    if (bus.hi !== m_hi || bus.lo !== m_lo) begin
      errors++;
      $display("FAIL mt_write: hi=%h lo=%h want hi=%h lo=%h", bus.hi, bus.lo, m_hi, m_lo);
    end
  endtask

  task automatic test_reset();
    bus.start    = 1'b0;
    bus.md_op    = 2'b00;
    bus.hilo_we  = 1'b0;
    bus.hilo_sel = 1'b0;
    bus.A        = 32'd0;
    bus.B        = 32'd0;
    reset        = 1'b0;
    m_hi         = 32'd0;
    m_lo         = 32'd0;
    repeat (3) @(negedge clk);
    checks++;
    if (bus.busy !== 1'b0 || bus.stall_req !== 1'b0 || bus.hi !== 32'd0 || bus.lo !== 32'd0) begin
      errors++;
      $display("FAIL reset_state: busy=%b stall=%b hi=%h lo=%h want 0", bus.busy, bus.stall_req,
               bus.hi, bus.lo);
    end
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_mult();
    run_op("mult_signed", 2'b00, 32'hFFFF_FFFF, 32'h0000_0002);
    checks++;
    if (bus.hi !== 32'hFFFF_FFFF || bus.lo !== 32'hFFFF_FFFE) begin
      errors++;
      $display("FAIL mult_signed_const: hi=%h lo=%h want ffffffff fffffffe", bus.hi, bus.lo);
    end
    @(negedge clk);
    run_op("mult_unsigned", 2'b01, 32'hFFFF_FFFF, 32'h0000_0002);
    checks++;
    if (bus.hi !== 32'h0000_0001 || bus.lo !== 32'hFFFF_FFFE) begin
      errors++;
      $display("FAIL multu_const: hi=%h lo=%h want 00000001 fffffffe", bus.hi, bus.lo);
    end
  endtask

  task automatic test_div();
    @(negedge clk);
    run_op("div_neg7_by_2", 2'b10, 32'hFFFF_FFF9, 32'h0000_0002);
    checks++;
    if (bus.hi !== 32'hFFFF_FFFF || bus.lo !== 32'hFFFF_FFFD) begin
      errors++;
      $display("FAIL div_const: hi=%h lo=%h want ffffffff fffffffd", bus.hi, bus.lo);
    end
    run_op("div_overflow", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF);
    checks++;
    if (bus.hi !== 32'h0000_0000 || bus.lo !== 32'h8000_0000) begin
      errors++;
      $display("FAIL div_overflow_const: hi=%h lo=%h want 00000000 80000000", bus.hi, bus.lo);
    end
    run_op("divu", 2'b11, 32'hFFFF_FFF9, 32'h0000_0010);
    run_op("div_pos_by_neg", 2'b10, 32'd100, 32'hFFFF_FFF9);
  endtask

  task automatic test_div_zero();
    do_mt(1'b1, 32'h0000_1234);
    do_mt(1'b0, 32'h0000_5678);
    run_op("divu_by_zero", 2'b11, 32'd7, 32'd0);
    checks++;
    if (bus.hi !== 32'h0000_1234 || bus.lo !== 32'h0000_5678) begin
      errors++;
      $display("FAIL div_zero_keep: hi=%h lo=%h want 00001234 00005678", bus.hi, bus.lo);
    end
    run_op("div_by_zero", 2'b10, 32'hFFFF_0000, 32'd0);
  endtask

  task automatic test_ignored();
    int          cycles;
    logic [31:0] old_hi;
    logic [31:0] old_lo;
    old_hi = m_hi;
    old_lo = m_lo;
    @(negedge clk);
    bus.start = 1'b1;
    bus.md_op = 2'b00;
    bus.A     = 32'd1000;
    bus.B     = 32'hFFFF_FFFD;
    @(negedge clk);
    bus.start = 1'b0;
    cycles    = 0;
    while (bus.busy === 1'b1 && cycles < 40) begin
      cycles++;
      if (cycles == 2) begin
        bus.start    = 1'b1;
        bus.md_op    = 2'b10;
        bus.hilo_we  = 1'b1;
        bus.hilo_sel = 1'b1;
        bus.A        = 32'hDEAD_BEEF;
        bus.B        = 32'd3;
      end else begin
        bus.start   = 1'b0;
        bus.hilo_we = 1'b0;
      end
      #1;
      checks++;
      if (bus.stall_req !== 1'b1 || bus.hi !== old_hi || bus.lo !== old_lo) begin
        errors++;
        $display("FAIL ignored_hold: stall=%b hi=%h lo=%h want 1 %h %h", bus.stall_req,
                 bus.hi, bus.lo, old_hi, old_lo);
      end
      @(negedge clk);
    end
    bus.start   = 1'b0;
    bus.hilo_we = 1'b0;
    checks++;
    if (cycles != MULT_N) begin
      errors++;
      $display("FAIL ignored_busy_cycles: got %0d want %0d", cycles, MULT_N);
    end
    model_op(2'b00, 32'd1000, 32'hFFFF_FFFD);
    checks++;
    if (bus.hi !== m_hi || bus.lo !== m_lo || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL ignored_result: hi=%h lo=%h busy=%b want %h %h 0", bus.hi, bus.lo,
               bus.busy, m_hi, m_lo);
    end
    repeat (12) @(negedge clk);
    checks++;
    if (bus.hi !== m_hi || bus.lo !== m_lo || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL ignored_no_second_op: hi=%h lo=%h busy=%b want %h %h 0", bus.hi, bus.lo,
               bus.busy, m_hi, m_lo);
    end
  endtask

  task automatic test_back_to_back();
    logic [1:0] op;
    for (int k = 0; k < 6; k++) begin
      op = 2'(k % 4);
      run_op("back_to_back", op, $urandom, $urandom_range(1, 32'h7FFF_FFFF));
    end
  endtask

  task automatic test_random();
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    for (int k = 0; k < 24; k++) begin
      op = 2'($urandom_range(0, 3));
      a  = $urandom;
      case ($urandom_range(0, 5))
        0:       b = 32'd0;
        1:       b = 32'($urandom_range(1, 15));
        2:       b = 32'hFFFF_FFFF;
        default: b = $urandom;
      endcase
      if ($urandom_range(0, 7) == 0) a = 32'h8000_0000;
      if ($urandom_range(0, 3) == 0) do_mt(1'($urandom_range(0, 1)), $urandom);
      repeat ($urandom_range(0, 2)) @(negedge clk);
      run_op("random_op", op, a, b);
    end
  endtask

  task automatic test_reset_mid();
    int cycles;
    do_mt(1'b1, 32'hAAAA_5555);
    do_mt(1'b0, 32'h1357_9BDF);
    bus.start = 1'b1;
    bus.md_op = 2'b10;
    bus.A     = 32'd1000;
    bus.B     = 32'd7;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    #1;
    m_hi = 32'd0;
    m_lo = 32'd0;
    checks++;
    if (bus.busy !== 1'b0 || bus.hi !== 32'd0 || bus.lo !== 32'd0) begin
      errors++;
      $display("FAIL reset_mid_immediate: busy=%b hi=%h lo=%h want 0 0 0", bus.busy, bus.hi,
               bus.lo);
    end
    @(negedge clk);
    reset  = 1'b1;
    cycles = 0;
    repeat (12) begin
      @(negedge clk);
      if (bus.busy !== 1'b0 || bus.hi !== 32'd0 || bus.lo !== 32'd0) cycles++;
    end
    checks++;
    if (cycles != 0) begin
      errors++;
      $display("FAIL reset_mid_no_commit: %0d bad cycles, hi=%h lo=%h want 0 bad cycles",
               cycles, bus.hi, bus.lo);
    end
    run_op("mult_after_reset", 2'b00, 32'h0001_0000, 32'hFFFF_0003);
  endtask

  initial begin
    errors = 0;
    checks = 0;
    test_reset();
    test_mult();
    test_div();
    test_div_zero();
    test_ignored();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mult_div_unit.md
# mult_div_unit

Execute-stage multiply/divide unit for the five-stage MIPS pipeline. It takes the forwarded RS/RT operand values produced in E (after forwarding muxes) and runs mult/multu/div/divu with fixed multi-cycle latency into the architectural HI/LO registers. It also performs mthi/mtlo writes and exposes HI/LO for mfhi/mflo, whose results the E/M pipeline register carries forward. It raises a stall request so the hazard unit holds any HI/LO-touching instruction in D while an operation is in flight.

## Interface
Parameters:
- MULT_CYCLES, 5, busy cycles for mult/multu
- DIV_CYCLES, 10, busy cycles for div/divu

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-low; clears all state
- start  input  1  one-cycle pulse launching the operation selected by md_op
- md_op  input  2  00 mult, 01 multu, 10 div, 11 divu
- hilo_we  input  1  mthi/mtlo write enable
- hilo_sel  input  1  0 writes LO (mtlo), 1 writes HI (mthi)
- A  input  32  forwarded RS value (multiplicand/dividend, mt source)
- B  input  32  forwarded RT value (multiplier/divisor)
- busy  output  1  operation in flight
- stall_req  output  1  combinational start | busy
- hi  output  32  current HI
- lo  output  32  current LO

## Operation
- Clock and reset: single clock domain, clk; reset is asynchronous and active-low. While reset is 0: busy=0, counter=0, hi=0, lo=0, pending result registers=0.
- States: IDLE, RUN.
- IDLE + start=1 at an edge: compute the full result from A, B, and md_op, and latch it into pending_hi/pending_lo. Load the counter with MULT_CYCLES (md_op[1]=0) or DIV_CYCLES (md_op[1]=1). Move to RUN.
- RUN: decrement the counter at each edge. At the edge where the counter reaches 1, commit pending_hi/pending_lo to hi/lo, then go to IDLE.
- Arithmetic rules:
  - mult: 64-bit signed product {HI,LO}.
  - multu: 64-bit unsigned product {HI,LO}.
  - div: LO = quotient truncated toward zero; HI = remainder with the sign of the dividend.
  - div 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0.
  - divu: unsigned quotient/remainder.
  - Divide by zero (div or divu): the operation still takes DIV_CYCLES with busy=1, but hi/lo are left unchanged at the end.
- mthi/mtlo: when hilo_we=1 and state is IDLE and start=0, write A into the selected register at the edge.
- Ignored events:
  - hilo_we while in RUN.
  - start while in RUN; busy and the result in flight are unaffected.
- Simultaneous start and hilo_we in IDLE: start wins and the write is dropped. The controller never issues this combination.
- hi/lo outputs change only at commit, mt write, or reset.

## Timing
- start sampled at edge T0.
- busy=1 for the cycles after edges T0 .. T0+N-1, where N = MULT_CYCLES or DIV_CYCLES.
- hi/lo take the new value and busy falls at edge T0+N. A mfhi/mflo issued in the cycle after edge T0+N reads the new value.
- stall_req is high in the start cycle and for all N busy cycles, so an instruction held in D is released once busy is low.
- Back-to-back operations: a start in the first cycle after busy falls is accepted. The minimum issue interval is N+1 cycles.
- Reset asserted mid-RUN: immediately busy=0, hi=lo=0, and the pending result is discarded. No commit happens after reset releases.
- The counter width covers max(MULT_CYCLES, DIV_CYCLES). The counter never wraps, because it is only decremented in RUN and exits at 1.

## Test plan
- Signed mult: A=0xFFFFFFFF, B=0x00000002, md_op=00, start pulse.
  - busy is high for exactly 5 cycles.
  - Then hi=0xFFFFFFFF, lo=0xFFFFFFFE.
  - hi/lo hold their old values during busy.
- Unsigned mult: same operands with md_op=01.
  - hi=0x00000001, lo=0xFFFFFFFE after 5 cycles.
- Signed divide: A=0xFFFFFFF9 (-7), B=2, md_op=10.
  - busy is high for 10 cycles.
  - Then lo=0xFFFFFFFD, hi=0xFFFFFFFF.
  - Overflow case A=0x80000000, B=0xFFFFFFFF gives lo=0x80000000, hi=0.
- Divide by zero: mthi 0x1234, mtlo 0x5678, then divu A=7, B=0.
  - busy is high for 10 cycles.
  - hi=0x00001234 and lo=0x00005678 are unchanged.
- Ignored requests: start a mult, then pulse start (div) and hilo_we during busy cycle 2.
  - The mult result commits at the 5-cycle point.
  - Neither the second start nor the write has any effect.
  - stall_req stays high throughout.
- Reset mid-operation: launch a div, then pull reset low at busy cycle 4 and release it.
  - busy=0 and hi=lo=0 immediately.
  - No commit follows.
  - A new mult started afterwards completes normally in 5 cycles.
